// File: rtl/peripheral_timer.sv
// 16-bit memory-mapped timer/counter for the J1 I/O bus: prescaler, compare match,
// one-shot or auto-reload operation, sticky match flag and level interrupt.
module peripheral_timer #(
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd49,
  parameter logic [15:0] DEFAULT_COMPARE  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        irq
);

  localparam logic [3:0] ADDR_CTRL     = 4'h0;
  localparam logic [3:0] ADDR_PRESCALE = 4'h2;
  localparam logic [3:0] ADDR_COMPARE  = 4'h4;
  localparam logic [3:0] ADDR_COUNT    = 4'h6;
  localparam logic [3:0] ADDR_STATUS   = 4'h8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] compare_q, compare_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        flag_q, flag_d;

  logic wr_en, ctrl_wr, prescale_wr, compare_wr, count_wr, status_wr;
  logic tick, match, running;

  assign wr_en       = cs & wr;
  assign ctrl_wr     = wr_en && (addr == ADDR_CTRL);
  assign prescale_wr = wr_en && (addr == ADDR_PRESCALE);
  assign compare_wr  = wr_en && (addr == ADDR_COMPARE);
  assign count_wr    = wr_en && (addr == ADDR_COUNT);
  assign status_wr   = wr_en && (addr == ADDR_STATUS);

  // >= so that lowering PRESCALE below the running PCNT ticks immediately
  assign tick = (state_q == S_RUN) && (pcnt_q >= prescale_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 3'b000;
      prescale_q <= DEFAULT_PRESCALE;
      compare_q  <= DEFAULT_COMPARE;
      count_q    <= 16'h0000;
      pcnt_q     <= 16'h0000;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      pcnt_q     <= pcnt_d;
      flag_q     <= flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    pcnt_d     = pcnt_q;
    flag_d     = flag_q;
    match      = 1'b0;

    // A COUNT write on a tick cycle discards the whole tick action on the counter
    if (state_q == S_RUN) begin
      if (tick) begin
        pcnt_d = 16'h0000;
        if (!count_wr) begin
          if (count_q == compare_q) begin
            match = 1'b1;
            if (ctrl_q[CTRL_AUTO]) begin
              count_d = 16'h0000;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            count_d = count_q + 16'd1;
          end
        end
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end

    if (ctrl_wr) begin
      ctrl_d = d_in[2:0];
      if (d_in[CTRL_EN]) begin
        if (state_q == S_IDLE) begin
          state_d = S_RUN;
          pcnt_d  = 16'h0000;
        end else if (state_q == S_DONE) begin
          state_d = S_RUN;
          pcnt_d  = 16'h0000;
          count_d = 16'h0000;
        end
      end else begin
        state_d = S_IDLE;
        if (state_q == S_RUN) begin
          count_d = count_q;
          pcnt_d  = pcnt_q;
          match   = 1'b0;
        end
      end
    end

    if ((state_q == S_RUN) && (state_d == S_DONE)) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end

    if (prescale_wr) prescale_d = d_in;
    if (compare_wr)  compare_d  = d_in;
    if (count_wr)    count_d    = d_in;

    // Set wins over a simultaneous write-1-to-clear
    if (status_wr && d_in[0]) flag_d = 1'b0;
    if (match)                flag_d = 1'b1;
  end

  always_comb begin
    running = (state_q == S_RUN);
    irq     = flag_q & ctrl_q[CTRL_IRQ_EN];
    d_out   = 16'h0000;
    if (cs && rd) begin
      case (addr)
        ADDR_CTRL:     d_out = {13'h0000, ctrl_q};
        ADDR_PRESCALE: d_out = prescale_q;
        ADDR_COMPARE:  d_out = compare_q;
        ADDR_COUNT:    d_out = count_q;
        ADDR_STATUS:   d_out = {14'h0000, running, flag_q};
        default:       d_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_timer.sv
// Directed and randomized checks of peripheral_timer against a behavioural register-level model.
module tb_peripheral_timer;

  logic        clk;
  logic        rst;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;
  logic        irq;

  int checks;
  int errors;

  peripheral_timer dut (
    .clk   (clk),
    .rst   (rst),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model state; m_mode: 0 = stopped, 1 = counting, 2 = finished one-shot
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre, m_cmp, m_cnt, m_pcnt;
  logic        m_flag;
  int          m_mode;

  task automatic model_step(input logic r, input logic w, input logic [3:0] a,
                            input logic [15:0] d);
    logic [2:0]  n_ctrl;
    logic [15:0] n_pre, n_cmp, n_cnt, n_pcnt;
    logic        n_flag;
    int          n_mode;
    bit          hit;
    if (r) begin
      m_ctrl = 3'b000; m_pre = 16'd49; m_cmp = 16'hFFFF;
      m_cnt = 16'h0000; m_pcnt = 16'h0000; m_flag = 1'b0; m_mode = 0;
      return;
    end
    n_ctrl = m_ctrl; n_pre = m_pre; n_cmp = m_cmp; n_cnt = m_cnt;
    n_pcnt = m_pcnt; n_flag = m_flag; n_mode = m_mode; hit = 0;
    if (m_mode == 1) begin
      if (m_pcnt < m_pre) begin
        n_pcnt = m_pcnt + 16'd1;
      end else begin
        n_pcnt = 16'h0000;
        if (!(w && a == 4'h6)) begin
          if (m_cnt == m_cmp) begin
            hit = 1;
            if (m_ctrl[1]) n_cnt = 16'h0000;
            else n_mode = 2;
          end else begin
            n_cnt = m_cnt + 16'd1;
          end
        end
      end
    end
    if (w) begin
      case (a)
        4'h0: begin
          n_ctrl = d[2:0];
          if (d[0]) begin
            if (m_mode == 0) begin n_mode = 1; n_pcnt = 16'h0000; end
            if (m_mode == 2) begin n_mode = 1; n_pcnt = 16'h0000; n_cnt = 16'h0000; end
          end else begin
            n_mode = 0;
            if (m_mode == 1) begin n_cnt = m_cnt; n_pcnt = m_pcnt; hit = 0; end
          end
        end
        4'h2: n_pre = d;
        4'h4: n_cmp = d;
        4'h6: n_cnt = d;
        4'h8: if (d[0]) n_flag = 1'b0;
        default: ;
      endcase
    end
    if (m_mode == 1 && n_mode == 2) n_ctrl[0] = 1'b0;
    if (hit) n_flag = 1'b1;
    m_ctrl = n_ctrl; m_pre = n_pre; m_cmp = n_cmp; m_cnt = n_cnt;
    m_pcnt = n_pcnt; m_flag = n_flag; m_mode = n_mode;
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] a);
    case (a)
      4'h0:    return {13'h0000, m_ctrl};
      4'h2:    return m_pre;
      4'h4:    return m_cmp;
      4'h6:    return m_cnt;
      4'h8:    return {14'h0000, (m_mode == 1), m_flag};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(rst, cs & wr, addr, d_in);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    step();
    $display("write addr=%h data=%h", a, d);
    cs = 1'b0; wr = 1'b0; d_in = 16'h0000;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1;
    $display("read  addr=%h data=%h", a, d_out);
    chk(tag, d_out, exp);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {15'h0000, irq}, {15'h0000, exp});
  endtask

  initial begin
    logic [15:0] e;
    checks = 0; errors = 0;
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;

    // 1: reset and readback
    step(); step();
    rst = 1'b0;
    chk_reg("rst_ctrl", 4'h0, 16'h0000);
    chk_reg("rst_prescale", 4'h2, 16'h0031);
    chk_reg("rst_compare", 4'h4, 16'hFFFF);
    chk_reg("rst_count", 4'h6, 16'h0000);
    chk_reg("rst_status", 4'h8, 16'h0000);
    chk_reg("rst_unmapped", 4'hA, 16'h0000);
    chk_irq("rst_irq", 1'b0);

    // 2: one-shot timing, match exactly 20 clocks after enabling
    bus_write(4'h2, 16'd3);
    bus_write(4'h4, 16'd4);
    bus_write(4'h0, 16'h0005);
    for (int i = 1; i < 20; i++) begin
      step();
      chk_irq("oneshot_irq_early", 1'b0);
    end
    step();
    chk_irq("oneshot_irq_at20", 1'b1);
    chk_reg("oneshot_status", 4'h8, 16'h0001);
    chk_reg("oneshot_count", 4'h6, 16'd4);
    chk_reg("oneshot_ctrl", 4'h0, 16'h0004);
    for (int i = 0; i < 50; i++) begin
      step();
      chk_reg("oneshot_hold", 4'h6, 16'd4);
    end

    // 3: auto-reload with PRESCALE 0 and COMPARE 2
    bus_write(4'h8, 16'h0001);
    bus_write(4'h2, 16'd0);
    bus_write(4'h4, 16'd2);
    bus_write(4'h0, 16'h0003);
    chk_reg("auto_cnt0", 4'h6, 16'd0);
    chk_reg("auto_status0", 4'h8, 16'h0002);
    step(); chk_reg("auto_cnt1", 4'h6, 16'd1);
    step(); chk_reg("auto_cnt2", 4'h6, 16'd2);
    chk_reg("auto_noflag", 4'h8, 16'h0002);
    step(); chk_reg("auto_wrap", 4'h6, 16'd0);
    chk_reg("auto_flag", 4'h8, 16'h0003);
    step(); chk_reg("auto_cnt1b", 4'h6, 16'd1);
    step(); chk_reg("auto_cnt2b", 4'h6, 16'd2);

    // 4: clear on the match-tick edge, set wins
    bus_write(4'h8, 16'h0001);
    chk_reg("setwins_status", 4'h8, 16'h0003);
    chk_reg("setwins_count", 4'h6, 16'd0);

    // 3 (cont.): clear, then flag returns at the next wrap
    bus_write(4'h8, 16'h0001);
    chk_reg("clear_status", 4'h8, 16'h0002);
    step(); chk_reg("clear_still0", 4'h8, 16'h0002);
    step(); chk_reg("clear_reset", 4'h8, 16'h0003);
    chk_irq("auto_irq_masked", 1'b0);

    // 5: wrap through 0xFFFF after a mid-run COUNT load
    bus_write(4'h0, 16'h0000);
    chk_reg("stop_count_held", 4'h6, 16'd0);
    bus_write(4'h8, 16'h0001);
    bus_write(4'h4, 16'd5);
    bus_write(4'h0, 16'h0001);
    bus_write(4'h6, 16'hFFFE);
    chk_reg("load_count", 4'h6, 16'hFFFE);
    for (int k = 1; k <= 7; k++) begin
      step();
      e = 16'hFFFE + 16'(k);
      chk_reg("wrap_count", 4'h6, e);
      chk_reg("wrap_noflag", 4'h8, 16'h0002);
    end
    step();
    chk_reg("wrap_match_status", 4'h8, 16'h0001);
    chk_reg("wrap_match_count", 4'h6, 16'd5);
    chk_reg("wrap_match_ctrl", 4'h0, 16'h0000);

    // 6: reset in the middle of a run
    bus_write(4'h2, 16'd9);
    bus_write(4'h0, 16'h0005);
    bus_write(4'h6, 16'd7);
    chk_reg("pre_rst_count", 4'h6, 16'd7);
    chk_reg("pre_rst_status", 4'h8, 16'h0003);
    chk_irq("pre_rst_irq", 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_reg("mid_rst_ctrl", 4'h0, 16'h0000);
    chk_reg("mid_rst_prescale", 4'h2, 16'h0031);
    chk_reg("mid_rst_compare", 4'h4, 16'hFFFF);
    chk_reg("mid_rst_count", 4'h6, 16'h0000);
    chk_reg("mid_rst_status", 4'h8, 16'h0000);
    chk_irq("mid_rst_irq", 1'b0);
    cs = 1'b0; rd = 1'b1; addr = 4'h2; #1;
    chk("unselected_read", d_out, 16'h0000);
    rd = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] exp_rd;
      rst  = ($urandom_range(0, 199) == 0);
      cs   = ($urandom_range(0, 3) != 0);
      rd   = $urandom_range(0, 1);
      wr   = ($urandom_range(0, 9) < 3);
      addr = ($urandom_range(0, 3) != 0) ? 4'(2 * $urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      case (addr)
        4'h0:    d_in = 16'($urandom_range(0, 7));
        4'h2:    d_in = 16'($urandom_range(0, 3));
        4'h4:    d_in = 16'($urandom_range(0, 12));
        4'h6:    d_in = ($urandom_range(0, 7) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                  : 16'($urandom_range(0, 15));
        default: d_in = 16'($urandom);
      endcase
      #1;
      exp_rd = (cs && rd) ? model_read(addr) : 16'h0000;
      $display("rand %0d rst=%b cs=%b rd=%b wr=%b addr=%h din=%h dout=%h irq=%b",
               i, rst, cs, rd, wr, addr, d_in, d_out, irq);
      chk("rand_dout", d_out, exp_rd);
      chk_irq("rand_irq", m_flag & m_ctrl[2]);
      step();
      rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    end
    chk_reg("final_ctrl", 4'h0, model_read(4'h0));
    chk_reg("final_count", 4'h6, model_read(4'h6));
    chk_reg("final_status", 4'h8, model_read(4'h8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_timer.md
Name: peripheral_timer

Overview:
- Memory-mapped 16-bit timer/counter peripheral on the J1 I/O bus, alongside the mult, div, uart and dp_ram peripherals.
- The SoC address decoder drives `cs` for page 8'h71; the block decodes `j1_io_addr[3:0]` internally.
- Provides a programmable prescaler, an up-counter with compare match, one-shot or auto-reload operation, a sticky match flag and a level interrupt output.

Parameters:
- DEFAULT_PRESCALE, 16'd49, reset value of PRESCALE (1 us tick at 50 MHz).
- DEFAULT_COMPARE, 16'hFFFF, reset value of COMPARE.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- d_in  input  16  write data from J1 (`j1_io_dout`).
- cs  input  1  chip select from SoC decoder.
- addr  input  4  register offset (`j1_io_addr[3:0]`).
- rd  input  1  J1 read strobe.
- wr  input  1  J1 write strobe.
- d_out  output  16  read data to J1 read mux.
- irq  output  1  level interrupt = FLAG & CTRL.IRQ_EN.

Behaviour:
- Register map:
  - 0x0 CTRL (R/W): bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x2 PRESCALE (R/W).
  - 0x4 COMPARE (R/W).
  - 0x6 COUNT (R/W): write loads the counter.
  - 0x8 STATUS: read bit0 FLAG, bit1 RUNNING; write 1 to bit0 clears FLAG.
  - Other offsets read 16'h0000; writes to them are ignored.
- Writes take effect on the clk edge where cs & wr = 1.
- Reads are combinational: d_out = register selected by addr when cs & rd, else 16'h0000. Zero latency.
- Reset values:
  - CTRL = 0, PRESCALE = DEFAULT_PRESCALE, COMPARE = DEFAULT_COMPARE.
  - COUNT = 0, prescaler counter PCNT = 0, FLAG = 0.
  - State IDLE, irq = 0, d_out = 0.
- FSM states and transitions:
  - IDLE: counter frozen, RUNNING = 0. CTRL write with EN = 1 -> RUN; PCNT cleared, COUNT keeps its value.
  - RUN (RUNNING = 1):
    - PCNT increments each clk.
    - When PCNT >= PRESCALE: tick, PCNT <= 0. The >= comparison makes a PRESCALE reduced below PCNT mid-run tick on the next cycle.
    - On tick with COUNT != COMPARE: COUNT <= COUNT + 1, wrapping 16'hFFFF -> 0.
    - On tick with COUNT == COMPARE: FLAG <= 1. If AUTO_RELOAD, COUNT <= 0 and stay in RUN. Else COUNT holds and go to DONE; hardware also clears CTRL.EN.
    - CTRL write with EN = 0 -> IDLE, with COUNT and PCNT held.
  - DONE: RUNNING = 0, COUNT frozen at COMPARE. CTRL write with EN = 1 -> RUN with COUNT <= 0 and PCNT <= 0. CTRL write with EN = 0 -> IDLE.
- Timing:
  - Period between matches in auto-reload = (COMPARE+1)*(PRESCALE+1) clks.
  - FLAG becomes visible on the edge of the matching tick; irq follows FLAG combinationally.
- Boundary conditions:
  - PRESCALE = 0: tick every clk.
  - COMPARE = 0 with auto-reload: FLAG set on every tick.
  - COUNT written above COMPARE: counts up, wraps through 0, matches later.
  - COUNT write while RUN: the written value replaces the next value; that cycle's tick increment is discarded; PCNT is unaffected.
  - STATUS clear and a match in the same cycle: set wins, FLAG = 1.
  - COMPARE written while RUN: the new value is used from the next tick.
  - rst asserted mid-operation: all state returns to reset values on that edge, regardless of cs, wr or tick.
  - rd and wr together: the write occurs; d_out shows the pre-write value during that cycle.

Test Plan:
1. Reset/readback: assert rst 2 clks, then read offsets 0x0/0x2/0x4/0x6/0x8 -> 0x0000/0x0031/0xFFFF/0x0000/0x0000; irq = 0.
2. One-shot timing: PRESCALE = 3, COMPARE = 4, CTRL = 0x0005 -> FLAG and irq rise exactly 20 clks after the CTRL write edge. Then STATUS reads 0x0001, COUNT reads 4, CTRL reads 0x0004, and COUNT stays 4 for 50 clks.
3. Auto-reload: PRESCALE = 0, COMPARE = 2, CTRL = 0x0003 -> COUNT sequence 0,1,2,0,1,2; FLAG set at first wrap. Write STATUS = 1 -> FLAG clears, then re-sets 3 clks later.
4. Set-beats-clear: arrange the STATUS = 1 write on the exact match-tick cycle -> FLAG reads 1 afterwards.
5. Wrap and mid-run load: COMPARE = 5, PRESCALE = 0, run, write COUNT = 0xFFFE -> COUNT goes FFFE, FFFF, 0000 … 0005, then FLAG = 1.
6. Reset mid-run: with PRESCALE = 9, COUNT = 7, FLAG = 1, pulse rst 1 clk -> all registers at reset values, RUNNING = 0, irq = 0 on the following cycle; chip-unselected reads (cs = 0) -> d_out = 0x0000.
